micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter FETCH_ADDR, default 16'h0010, is the control-memory address of the common fetch routine.
REQ-002 Parameter STACK_DEPTH, default 4, is the number of micro-return-stack entries.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  leave IDLE/HALT and begin at FETCH_ADDR.
REQ-006 stall  in  1  hold all sequencer state this cycle (memory wait).
REQ-007 cu_entry  in  16  micro-routine entry address from the opcode decoder; 16'h0000 means HLT/illegal.
REQ-008 seq_ctl  in  3  next-address control field of the current microword.
REQ-009 cond_sel  in  3  branch-condition select of the current microword.
REQ-010 seq_target  in  16  branch/call target field of the current microword.
REQ-011 flag_z, flag_c  in  1 each  ALU zero and carry flags.
REQ-012 upc  out  16  registered micro-program counter; drives the control-memory address.
REQ-013 running  out  1  high in RUN state.
REQ-014 halted  out  1  high in HALT state.
REQ-015 instr_done  out  1  one-cycle pulse when a FETCH microword retires.
REQ-016 ucode_err  out  1  sticky micro-stack overflow/underflow error.

Function
REQ-017 States SHALL be IDLE, RUN, HALT; IDLE->RUN and HALT->RUN on start; RUN->HALT per REQ-021/022/023.
REQ-018 In IDLE/HALT, upc SHALL hold; start SHALL set upc=FETCH_ADDR, clear the stack and ucode_err, enter RUN next cycle.
REQ-019 In RUN with stall=1, upc, state, stack and flags outputs SHALL hold and instr_done SHALL be 0.
REQ-020 In RUN with stall=0, seq_ctl SHALL select next upc: 0 NEXT upc+1; 1 JUMP seq_target; 2 COND seq_target if condition true else upc+1; 4 FETCH FETCH_ADDR with instr_done=1.
REQ-021 seq_ctl 3 DISPATCH SHALL load upc=cu_entry; cu_entry==16'h0000 SHALL instead hold upc and enter HALT.
REQ-022 seq_ctl 5 CALL SHALL push upc+1 and load seq_target; push when full SHALL set ucode_err, hold upc, enter HALT.
REQ-023 seq_ctl 6 RET SHALL pop into upc; pop when empty SHALL set ucode_err, hold upc, enter HALT; seq_ctl 7 SHALL enter HALT holding upc.
REQ-024 cond_sel SHALL evaluate: 0 Z; 1 !Z; 2 C&!Z; 3 C; 4 !C; 5 !C|Z; 6 always; 7 never.
REQ-025 upc+1 SHALL wrap 16'hFFFF->16'h0000 with no error.
REQ-026 Microword inputs SHALL be sampled in the same cycle upc presents them (control memory read is combinational); next-address latency is one cycle.
REQ-027 start asserted in RUN SHALL be ignored.

Reset
REQ-028 rst SHALL override all inputs including stall and start.
REQ-029 Reset values: state IDLE, upc=FETCH_ADDR, running=0, halted=0, instr_done=0, ucode_err=0, stack empty.
REQ-030 rst mid-routine SHALL discard stack contents and any pending pulse.

Structure
REQ-031 seq_ctl codes, cond_sel codes and state encoding SHALL live in shared package ucode_pkg.
REQ-032 The return stack SHALL be sub-module ustack (push, pop, full, empty, top), depth STACK_DEPTH, simultaneous push+pop never issued.

Verification
REQ-033 rst, start, microwords FETCH then DISPATCH with cu_entry=16'h0460 -> upc 0010, 0010->instr_done pulse, upc=0460 next cycle.
REQ-034 flag_z=1, COND cond_sel=0 target 16'h0500 at upc 0461 -> upc=0500; flag_z=0 -> upc=0462.
REQ-035 Five nested CALLs, STACK_DEPTH=4 -> fifth sets ucode_err=1, halted=1, upc unchanged; RET in fresh RUN with empty stack -> same.
REQ-036 DISPATCH with cu_entry=0 -> halted=1, upc held; start -> running=1, upc=0010, ucode_err=0.
REQ-037 stall=1 for 3 cycles during NEXT at upc FFFF -> upc holds FFFF; stall released -> upc=0000.
REQ-038 rst asserted mid-CALL chain with stall=1 -> next cycle IDLE, upc=0010, stack empty, all outputs 0.

Source files
------------

// File: rtl/ucode_pkg.sv
// Shared encodings for the micro-sequencer: next-address control, branch
// condition select, sequencer state, and the branch-condition evaluator.
package ucode_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_COND     = 3'd2,
    SEQ_DISPATCH = 3'd3,
    SEQ_FETCH    = 3'd4,
    SEQ_CALL     = 3'd5,
    SEQ_RET      = 3'd6,
    SEQ_HALT     = 3'd7
  } seq_ctl_e;

  typedef enum logic [2:0] {
    COND_Z      = 3'd0,
    COND_NZ     = 3'd1,
    COND_C_NZ   = 3'd2,
    COND_C      = 3'd3,
    COND_NC     = 3'd4,
    COND_NC_OR_Z = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_NEVER  = 3'd7
  } cond_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Opcode decoder reports HLT or an illegal opcode with this entry address.
  localparam logic [15:0] ENTRY_ILLEGAL = 16'h0000;

  // True when the selected branch condition holds for the given flags.
  function automatic logic cond_eval(input logic [2:0] sel, input logic z, input logic c);
    logic res;
    case (cond_sel_e'(sel))
      COND_Z:       res = z;
      COND_NZ:      res = !z;
      COND_C_NZ:    res = c && !z;
      COND_C:       res = c;
      COND_NC:      res = !c;
      COND_NC_OR_Z: res = !c || z;
      COND_ALWAYS:  res = 1'b1;
      default:      res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ustack.sv
// Micro-return stack: LIFO of return addresses. Overflow/underflow is
// detected by the caller through full/empty; requests that would overflow
// or underflow are simply ignored here.
module ustack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wr_idx, top_idx;

  assign full    = (cnt_q == PW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_idx  = IW'(cnt_q);
  assign top_idx = IW'(cnt_q - PW'(1));
  assign top     = empty ? '0 : mem_q[top_idx];

  // Occupancy update; clear wins over push/pop.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (push && !full) cnt_d = cnt_q + PW'(1);
    else if (pop && !empty) cnt_d = cnt_q - PW'(1);
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Entry storage; contents beyond the occupancy count are don't-care.
  always_ff @(posedge clk) begin
    if (!rst && !clr && push && !full) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: computes the next control-memory address from the
// current microword's next-address field, manages the return stack and the
// IDLE/RUN/HALT lifecycle.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | out of reset, upc parked at FETCH_ADDR, waiting for start
//   ST_RUN  | executing microwords, one next-address decision per cycle
//   ST_HALT | stopped by HLT/illegal, seq_ctl 7 or stack error; upc held
module micro_sequencer
  import ucode_pkg::*;
#(
  parameter logic [15:0] FETCH_ADDR  = 16'h0010,
  parameter int          STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic [15:0] cu_entry,
  input  logic [2:0]  seq_ctl,
  input  logic [2:0]  cond_sel,
  input  logic [15:0] seq_target,
  input  logic        flag_z,
  input  logic        flag_c,
  output logic [15:0] upc,
  output logic        running,
  output logic        halted,
  output logic        instr_done,
  output logic        ucode_err
);

  state_e      state_q, state_d;
  logic [15:0] upc_q, upc_d, upc_inc;
  logic        running_q, halted_q, instr_done_q, instr_done_d;
  logic        ucode_err_q, ucode_err_d;
  logic        stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [15:0] stk_top;

  assign upc_inc = upc_q + 16'd1;

  ustack #(.DEPTH(STACK_DEPTH), .W(16)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clr       (stk_clr),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (upc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next-address selection and lifecycle transitions.
  always_comb begin
    state_d      = state_q;
    upc_d        = upc_q;
    instr_done_d = 1'b0;
    ucode_err_d  = ucode_err_q;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_clr      = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d     = ST_RUN;
          upc_d       = FETCH_ADDR;
          ucode_err_d = 1'b0;
          stk_clr     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          case (seq_ctl_e'(seq_ctl))
            SEQ_NEXT: upc_d = upc_inc;
            SEQ_JUMP: upc_d = seq_target;
            SEQ_COND: upc_d = cond_eval(cond_sel, flag_z, flag_c) ? seq_target : upc_inc;
            SEQ_DISPATCH: begin
              if (cu_entry == ENTRY_ILLEGAL) state_d = ST_HALT;
              else                           upc_d   = cu_entry;
            end
            SEQ_FETCH: begin
              upc_d        = FETCH_ADDR;
              instr_done_d = 1'b1;
            end
            SEQ_CALL: begin
              if (stk_full) begin
                ucode_err_d = 1'b1;
                state_d     = ST_HALT;
              end else begin
                stk_push = 1'b1;
                upc_d    = seq_target;
              end
            end
            SEQ_RET: begin
              if (stk_empty) begin
                ucode_err_d = 1'b1;
                state_d     = ST_HALT;
              end else begin
                stk_pop = 1'b1;
                upc_d   = stk_top;
              end
            end
            default: state_d = ST_HALT;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      upc_q        <= FETCH_ADDR;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      instr_done_q <= 1'b0;
      ucode_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      upc_q        <= upc_d;
      running_q    <= (state_d == ST_RUN);
      halted_q     <= (state_d == ST_HALT);
      instr_done_q <= instr_done_d;
      ucode_err_q  <= ucode_err_d;
    end
  end

  assign upc        = upc_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign instr_done = instr_done_q;
  assign ucode_err  = ucode_err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: directed microword sequences checked every
// cycle against a queue-based behavioural model, plus literal spot checks.
module tb_micro_sequencer;

  localparam logic [15:0] FETCH = 16'h0010;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, stall = 1'b0;
  logic [15:0] cu_entry = 16'h1234, seq_target = 16'h0000;
  logic [2:0]  seq_ctl = 3'd0, cond_sel = 3'd0;
  logic        flag_z = 1'b0, flag_c = 1'b0;
  logic [15:0] upc;
  logic        running, halted, instr_done, ucode_err;

  int total = 0;
  int bad   = 0;

  micro_sequencer #(.FETCH_ADDR(FETCH), .STACK_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .cu_entry   (cu_entry),
    .seq_ctl    (seq_ctl),
    .cond_sel   (cond_sel),
    .seq_target (seq_target),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .upc        (upc),
    .running    (running),
    .halted     (halted),
    .instr_done (instr_done),
    .ucode_err  (ucode_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 halt
  int          m_mode = 0;
  logic [15:0] m_upc  = FETCH;
  logic [15:0] m_stack[$];
  bit          m_err = 0, m_done = 0, m_valid = 0;

  function automatic bit cond_ok(input int sel, input bit z, input bit c);
    bit t[8];
    t = '{z, !z, c && !z, c, !c, !c || z, 1'b1, 1'b0};
    return t[sel];
  endfunction

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m_done = 0;
    if (rst) begin
      m_mode = 0; m_upc = FETCH; m_stack.delete(); m_err = 0; m_valid = 1;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_upc = FETCH; m_stack.delete(); m_err = 0;
      end
    end else if (!stall) begin
      case (int'(seq_ctl))
        0: m_upc = m_upc + 16'd1;
        1: m_upc = seq_target;
        2: m_upc = cond_ok(int'(cond_sel), flag_z, flag_c) ? seq_target : m_upc + 16'd1;
        3: if (cu_entry == 16'h0000) m_mode = 2; else m_upc = cu_entry;
        4: begin m_upc = FETCH; m_done = 1; end
        5: if (m_stack.size() >= DEPTH) begin m_err = 1; m_mode = 2; end
           else begin m_stack.push_back(m_upc + 16'd1); m_upc = seq_target; end
        6: if (m_stack.size() == 0) begin m_err = 1; m_mode = 2; end
           else m_upc = m_stack.pop_back();
        default: m_mode = 2;
      endcase
    end
    #1;
    if (m_valid) begin
      cmp("model_upc", upc, m_upc);
      cmp("model_running", 16'(running), 16'(m_mode == 1));
      cmp("model_halted", 16'(halted), 16'(m_mode == 2));
      cmp("model_instr_done", 16'(instr_done), 16'(m_done));
      cmp("model_ucode_err", 16'(ucode_err), 16'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mw(input logic [2:0] ctl, input logic [2:0] cs = 3'd0,
                    input logic [15:0] tgt = 16'h0000, input logic [15:0] ent = 16'h1234);
    seq_ctl = ctl; cond_sel = cs; seq_target = tgt; cu_entry = ent;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset, then check reset values.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    cmp("rst_upc", upc, 16'h0010);
    cmp("rst_running", 16'(running), 16'h0);
    cmp("rst_halted", 16'(halted), 16'h0);
    cmp("rst_err", 16'(ucode_err), 16'h0);
    mw(3'd0);
    cmp("idle_hold_upc", upc, 16'h0010);

    // Fetch then dispatch.
    do_start();
    cmp("start_running", 16'(running), 16'h1);
    cmp("start_upc", upc, 16'h0010);
    mw(3'd4);
    cmp("fetch_upc", upc, 16'h0010);
    cmp("fetch_done", 16'(instr_done), 16'h1);
    mw(3'd3, 3'd0, 16'h0000, 16'h0460);
    cmp("dispatch_upc", upc, 16'h0460);
    cmp("dispatch_done_clear", 16'(instr_done), 16'h0);

    // Conditional branch on Z.
    mw(3'd0);
    flag_z = 1'b1;
    mw(3'd2, 3'd0, 16'h0500);
    cmp("cond_z_taken", upc, 16'h0500);
    mw(3'd1, 3'd0, 16'h0461);
    flag_z = 1'b0;
    mw(3'd2, 3'd0, 16'h0500);
    cmp("cond_z_not_taken", upc, 16'h0462);

    // Every condition against every flag combination.
    for (int cz = 0; cz < 4; cz++) begin
      for (int cs = 0; cs < 8; cs++) begin
        mw(3'd1, 3'd0, 16'h0100);
        flag_c = cz[1]; flag_z = cz[0];
        mw(3'd2, 3'(cs), 16'h0200);
      end
    end
    mw(3'd1, 3'd0, 16'h0100);
    flag_c = 1'b1; flag_z = 1'b0;
    mw(3'd2, 3'd5, 16'h0200);
    cmp("cond_ncz_false", upc, 16'h0101);
    mw(3'd2, 3'd2, 16'h0200);
    cmp("cond_cnz_true", upc, 16'h0200);

    // start in RUN is ignored.
    start = 1'b1;
    mw(3'd0);
    start = 1'b0;
    cmp("start_in_run_ignored", upc, 16'h0201);

    // Simple call/return.
    mw(3'd5, 3'd0, 16'h0700);
    mw(3'd0);
    mw(3'd6);
    cmp("ret_upc", upc, 16'h0202);

    // Five nested calls overflow a four-deep stack.
    mw(3'd1, 3'd0, 16'h0300);
    for (int i = 0; i < 4; i++) mw(3'd5, 3'd0, 16'h0400 + 16'(i));
    cmp("call4_upc", upc, 16'h0403);
    mw(3'd5, 3'd0, 16'h0404);
    cmp("overflow_err", 16'(ucode_err), 16'h1);
    cmp("overflow_halted", 16'(halted), 16'h1);
    cmp("overflow_upc", upc, 16'h0403);

    // Restart clears error; return with empty stack underflows.
    do_start();
    cmp("restart_upc", upc, 16'h0010);
    cmp("restart_err", 16'(ucode_err), 16'h0);
    mw(3'd6);
    cmp("underflow_err", 16'(ucode_err), 16'h1);
    cmp("underflow_halted", 16'(halted), 16'h1);
    cmp("underflow_upc", upc, 16'h0010);

    // Dispatch of illegal opcode halts without error.
    do_start();
    mw(3'd3, 3'd0, 16'h0000, 16'h0000);
    cmp("illegal_halted", 16'(halted), 16'h1);
    cmp("illegal_upc", upc, 16'h0010);
    cmp("illegal_err", 16'(ucode_err), 16'h0);
    do_start();
    cmp("illegal_restart_running", 16'(running), 16'h1);

    // seq_ctl 7 halts.
    mw(3'd1, 3'd0, 16'h0321);
    mw(3'd7);
    cmp("halt_code_upc", upc, 16'h0321);
    cmp("halt_code_halted", 16'(halted), 16'h1);
    mw(3'd0);
    cmp("halt_hold_upc", upc, 16'h0321);

    // Stall at FFFF, then wrap.
    do_start();
    mw(3'd1, 3'd0, 16'hFFFF);
    stall = 1'b1;
    mw(3'd0); mw(3'd4); mw(3'd0);
    cmp("stall_upc", upc, 16'hFFFF);
    cmp("stall_no_done", 16'(instr_done), 16'h0);
    stall = 1'b0;
    mw(3'd0);
    cmp("wrap_upc", upc, 16'h0000);
    cmp("wrap_err", 16'(ucode_err), 16'h0);

    // Reset mid call chain while stalled, start also asserted.
    mw(3'd5, 3'd0, 16'h0800);
    mw(3'd5, 3'd0, 16'h0900);
    stall = 1'b1; rst = 1'b1; start = 1'b1;
    mw(3'd5, 3'd0, 16'h0A00);
    stall = 1'b0; rst = 1'b0; start = 1'b0;
    cmp("midrst_upc", upc, 16'h0010);
    cmp("midrst_running", 16'(running), 16'h0);
    cmp("midrst_halted", 16'(halted), 16'h0);
    mw(3'd0);
    cmp("midrst_idle_upc", upc, 16'h0010);

    // Reset on a fetch cycle discards the pulse.
    do_start();
    rst = 1'b1;
    mw(3'd4);
    rst = 1'b0;
    cmp("rst_kills_done", 16'(instr_done), 16'h0);
    do_start();
    mw(3'd6);
    cmp("post_rst_stack_empty", 16'(ucode_err), 16'h1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
